grid_port_arbiter: RTL and testbench
====================================

# grid_port_arbiter

Owns port A of `Grid_Mem` and shares it between two requesters: requester 0 is `Grid_Controller`, and requester 1 is the grid loader/debug writer. It also contains a built-in clear engine that zero-fills the whole grid after reset and on request. It replaces the ad-hoc port-A mux: every port-A address, data and write-enable reaching `Grid_Mem` comes from this block.

## Interface
Parameters:
- `ADDR_W`, 8: grid address width; the grid depth is 2^ADDR_W.
- `DATA_W`, 8: grid cell width.
- `CLEAR_ON_RESET`, 1: when 1, a full clear runs automatically after reset release.

Ports:
- `clk`  in  1  single system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  ownership request; held high for the whole access sequence.
- `addr0`, `addr1`  in  ADDR_W  requester address.
- `wdata0`, `wdata1`  in  DATA_W  requester write data.
- `we0`, `we1`  in  1  requester write enable.
- `gnt0`, `gnt1`  out  1  registered ownership grant.
- `rvalid0`, `rvalid1`  out  1  `rdata` holds the result of this requester's read from the previous cycle.
- `rdata`  out  DATA_W  direct pass-through of `mem_q`.
- `clear_start`  in  1  one-cycle pulse that requests a full clear.
- `clear_busy`  out  1  a clear is pending or running.
- `clear_done`  out  1  one-cycle pulse after the last clear write.
- `mem_addr`  out  ADDR_W  to `Grid_Mem` `addr_a`.
- `mem_data`  out  DATA_W  to `Grid_Mem` `data_a`.
- `mem_we`  out  1  to `Grid_Mem` `we_a`.
- `mem_q`  in  DATA_W  from `Grid_Mem` `q_a`; read latency is 1 cycle.

## Operation
States: IDLE, OWN0, OWN1, CLEAR.

IDLE:
- If a clear is pending, go to CLEAR.
- Otherwise, if exactly one `req` is high, go to OWN0 or OWN1 for that requester.
- If both `req` are high, round-robin: grant the requester not granted last. `last` resets so that requester 0 wins the first tie.

OWNk:
- `gntk` stays high for as long as `reqk` stays high.
- There is no preemption, including by a clear.

Release from OWNk:
- The release is seen on the first edge with `reqk` low.
- The next state is chosen from IDLE rules on that same edge. This allows back-to-back handover: `gnt0` falls and `gnt1` rises on the same edge.
- A pending clear takes precedence over the other requester.

CLEAR:
- An internal counter sweeps addresses 0 to 2^ADDR_W−1.
- One write of zero per cycle: `mem_we` = 1, `mem_data` = 0.
- After address max, go to IDLE and pulse `clear_done` for 1 cycle.

Clear requests:
- `clear_start` sets a pending flag in any state.
- `clear_start` is ignored while in CLEAR.
- The pending flag clears on entry to CLEAR.

Output mux:
- OWNk: `mem_addr` = `addrk`, `mem_data` = `wdatak`, `mem_we` = `wek & reqk`. The release cycle therefore never writes.
- IDLE: `mem_addr` = 0, `mem_data` = 0, `mem_we` = 0.

Read valid:
- `rvalidk` is registered.
- It is high on the cycle after a cycle with `gntk & reqk & !wek`.

## Timing
- Reset values:
  - state = IDLE, `gnt0` = `gnt1` = 0.
  - `rvalid0` = `rvalid1` = 0, `clear_done` = 0.
  - clear pending = `CLEAR_ON_RESET`, counter = 0.
  - `mem_we` = 0, `mem_addr` = 0, `mem_data` = 0.
  - `clear_busy` = `CLEAR_ON_RESET`.
- `clear_busy` is combinational: pending OR (state == CLEAR).
- Grant latency: `req` high before edge N gives `gnt` high after edge N. The requester's address is on `mem_addr` in the cycle following edge N.
- Read: address presented in cycle C. `rdata` is valid and `rvalid` is high in cycle C+1.
- Clear duration: 2^ADDR_W cycles in CLEAR. With `CLEAR_ON_RESET`, the first write (address 0) occurs in the second cycle after reset release. `clear_done` is high the cycle after the address-max write.
- Asserting reset mid-clear or mid-ownership:
  - Outputs drop immediately to their reset values.
  - The sweep restarts from 0 when `CLEAR_ON_RESET` = 1, and is abandoned otherwise.
- Counter wrap: the sweep ends on address max. The counter never wraps back to 0 inside CLEAR.
- Simultaneous `clear_start` and `req` in IDLE: clear wins on the next edge, and `req` waits.

## Structure
- Package `grid_arb_pkg` holds:
  - the state enum (IDLE, OWN0, OWN1, CLEAR);
  - the default `ADDR_W`/`DATA_W`;
  - the constant `GRID_DEPTH = 2**ADDR_W`.
- Sub-module `grid_clear_sweep` holds the address counter with start/last/done. The arbiter FSM and output mux stay in the top module.

## Test plan
- `CLEAR_ON_RESET` = 1, preload address 54 = 0x01 before reset: release reset → `clear_busy` = 1, exactly 256 writes of 0x00 to addresses 0..255, then a `clear_done` pulse; a subsequent read of 54 returns 0x00.
- Idle, `req0` only: write 0x01 to address 65, then read 65 → `gnt0` one cycle after `req0`; `rvalid0` = 1 with `rdata` = 0x01 one cycle after the read address.
- `req0` and `req1` both high in IDLE with `last` = 1 → `gnt0` first. Drop `req0` → on that edge `gnt0` falls and `gnt1` rises; `mem_we` = 0 in the release cycle even with `we0` = 1.
- `clear_start` while OWN1 is held for 10 cycles → no preemption; `clear_busy` = 1 throughout; CLEAR begins on the edge `req1` is seen low; `gnt0` stays 0 during the sweep despite `req0` = 1.
- Reset asserted at sweep address 100 → outputs go to reset values asynchronously; after release the sweep restarts at address 0 and completes all 256 writes.

Source files
------------

// File: rtl/grid_arb_pkg.sv
// Shared types and defaults for the Grid_Mem port-A arbiter.
// Holds the arbiter state encoding and default grid geometry.
package grid_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int GRID_DEPTH = 2 ** ADDR_W_DEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OWN0,
    ST_OWN1,
    ST_CLEAR
  } arb_st_e;

endpackage

// File: rtl/grid_port_arbiter_if.sv
// Port-A bundle: two requesters, clear control and the Grid_Mem side.
// slave = arbiter view, master = requesters/memory view.
interface grid_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic              req0;
  logic              req1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              we0;
  logic              we1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              clear_start;
  logic              clear_busy;
  logic              clear_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_we;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req0, req1, addr0, addr1,
    input  wdata0, wdata1, we0, we1,
    input  clear_start, mem_q,
    output gnt0, gnt1, rvalid0, rvalid1,
    output rdata, clear_busy, clear_done,
    output mem_addr, mem_data, mem_we
  );

  modport master (
    output req0, req1, addr0, addr1,
    output wdata0, wdata1, we0, we1,
    output clear_start, mem_q,
    input  gnt0, gnt1, rvalid0, rvalid1,
    input  rdata, clear_busy, clear_done,
    input  mem_addr, mem_data, mem_we
  );

endinterface

// File: rtl/grid_clear_sweep.sv
// Address sweep for the clear engine: counts 0..max while run_i is high,
// flags the last address and pulses done_o the cycle after it.
module grid_clear_sweep #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              done_o
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  assign addr_o = cnt_q;
  assign last_o = (cnt_q == '1);
  assign done_o = done_q;

  // Return to 0 after the last address so the next sweep starts clean.
  always_comb begin
    cnt_d  = cnt_q;
    done_d = run_i & last_o;
    if (run_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/grid_port_arbiter.sv
// Owner of Grid_Mem port A: round-robin between two requesters
// plus a zero-fill clear engine that runs after reset and on demand.
module grid_port_arbiter
  import grid_arb_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  grid_port_arbiter_if.slave  bus
);

  arb_st_e st_q, st_d, idle_nxt;
  logic    last_q, last_d;
  logic    pend_q, pend_d;
  logic    rv0_q, rv0_d;
  logic    rv1_q, rv1_d;

  logic              own0, own1, clr;
  logic              clear_req;
  logic [ADDR_W-1:0] sw_addr;
  logic              sw_last;
  logic              sw_done;

  assign own0 = (st_q == ST_OWN0);
  assign own1 = (st_q == ST_OWN1);
  assign clr  = (st_q == ST_CLEAR);

  // A start pulse arriving this cycle already beats any requester.
  assign clear_req = pend_q | bus.clear_start;

  grid_clear_sweep #(
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clk    (clk),
    .rst_n  (reset),
    .run_i  (clr),
    .addr_o (sw_addr),
    .last_o (sw_last),
    .done_o (sw_done)
  );

  always_comb begin
    idle_nxt = ST_IDLE;
    if (clear_req) begin
      idle_nxt = ST_CLEAR;
    end else if (bus.req0 & bus.req1) begin
      idle_nxt = last_q ? ST_OWN0 : ST_OWN1;
    end else if (bus.req0) begin
      idle_nxt = ST_OWN0;
    end else if (bus.req1) begin
      idle_nxt = ST_OWN1;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE:  st_d = idle_nxt;
      ST_OWN0:  if (!bus.req0) st_d = idle_nxt;
      ST_OWN1:  if (!bus.req1) st_d = idle_nxt;
      ST_CLEAR: if (sw_last) st_d = ST_IDLE;
      default:  st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (st_d == ST_OWN0) begin
      last_d = 1'b0;
    end else if (st_d == ST_OWN1) begin
      last_d = 1'b1;
    end
    pend_d = pend_q;
    if (bus.clear_start && !clr) begin
      pend_d = 1'b1;
    end
    if (st_d == ST_CLEAR) begin
      pend_d = 1'b0;
    end
    rv0_d = own0 & bus.req0 & ~bus.we0;
    rv1_d = own1 & bus.req1 & ~bus.we1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q   <= ST_IDLE;
      last_q <= 1'b1;
      pend_q <= CLEAR_ON_RESET;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      last_q <= last_d;
      pend_q <= pend_d;
      rv0_q  <= rv0_d;
      rv1_q  <= rv1_d;
    end
  end

  // Gating we with req keeps the release cycle from writing.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_data = '0;
    bus.mem_we   = 1'b0;
    unique case (1'b1)
      own0: begin
        bus.mem_addr = bus.addr0;
        bus.mem_data = bus.wdata0;
        bus.mem_we   = bus.we0 & bus.req0;
      end
      own1: begin
        bus.mem_addr = bus.addr1;
        bus.mem_data = bus.wdata1;
        bus.mem_we   = bus.we1 & bus.req1;
      end
      clr: begin
        bus.mem_addr = sw_addr;
        bus.mem_we   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.gnt0       = own0;
  assign bus.gnt1       = own1;
  assign bus.rvalid0    = rv0_q;
  assign bus.rvalid1    = rv1_q;
  assign bus.rdata      = bus.mem_q;
  assign bus.clear_busy = pend_q | clr;
  assign bus.clear_done = sw_done;

endmodule

// File: tb/tb_grid_port_arbiter.sv
// Directed bench for grid_port_arbiter with a Grid_Mem model and
// write/read scoreboards.
module tb_grid_port_arbiter;
  import grid_arb_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic preload = 1'b1;

  always #5 clk = ~clk;

  grid_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  grid_port_arbiter #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem [GRID_DEPTH];

  always @(posedge clk) begin
    if (preload) mem[54] <= 8'h01;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_data;
    bus.mem_q <= mem[bus.mem_addr];
  end

  logic [15:0] wq [$];
  logic [8:0]  rq [$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] we_exp;
    logic [8:0]  re_exp;
    if (bus.mem_we === 1'b1) begin
      if (wq.size() == 0) chk("wr_spurious", 32'(bus.mem_we), 32'd0);
      else begin
        we_exp = wq.pop_front();
        chk("wr", {16'd0, bus.mem_addr, bus.mem_data}, {16'd0, we_exp});
      end
    end
    if (bus.rvalid0 === 1'b1 || bus.rvalid1 === 1'b1) begin
      if (rq.size() == 0)
        chk("rd_spurious", {30'd0, bus.rvalid1, bus.rvalid0}, 32'd0);
      else begin
        re_exp = rq.pop_front();
        chk("rd", {23'd0, bus.rvalid1, bus.rdata}, {23'd0, re_exp});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear();
    for (int a = 0; a < GRID_DEPTH; a++) wq.push_back({a[7:0], 8'h00});
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk({tag, "_first_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_first_we"}, 32'(bus.mem_we), 32'd1);
      end
      chk({tag, "_gnt0_low"}, 32'(bus.gnt0), 32'd0);
      if (bus.clear_done === 1'b1) begin
        chk({tag, "_done_cycle"}, 32'(i), 32'd257);
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus.clear_start = 0;

    repeat (3) @(posedge clk);
    #1 preload = 1'b0;
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_rv", {30'd0, bus.rvalid1, bus.rvalid0}, 0);
    chk("rst_done", 32'(bus.clear_done), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_data", 32'(bus.mem_data), 0);
    chk("rst_busy", 32'(bus.clear_busy), 1);

    push_clear();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_busy", 32'(bus.clear_busy), 1);
    chk("rel_we", 32'(bus.mem_we), 0);
    wait_done("clr1");
    #1;
    chk("clr1_busy_off", 32'(bus.clear_busy), 0);
    chk("clr1_wq_empty", 32'(wq.size()), 0);
    @(negedge clk);
    chk("clr1_done_pulse", 32'(bus.clear_done), 0);

    cyc();
    bus.req0 = 1; bus.addr0 = 8'd54; bus.we0 = 0;
    @(negedge clk);
    chk("rd54_gnt_idle", 32'(bus.gnt0), 0);
    cyc();
    rq.push_back({1'b0, 8'h00});
    @(negedge clk);
    chk("rd54_gnt", 32'(bus.gnt0), 1);
    chk("rd54_addr", 32'(bus.mem_addr), 54);
    cyc();
    bus.req0 = 0;
    cyc();

    bus.req0 = 1; bus.addr0 = 8'd65; bus.wdata0 = 8'h01; bus.we0 = 1;
    cyc();
    wq.push_back({8'd65, 8'h01});
    @(negedge clk);
    chk("wr65_gnt", 32'(bus.gnt0), 1);
    cyc();
    bus.we0 = 0;
    rq.push_back({1'b0, 8'h01});
    cyc();
    bus.req0 = 0;
    cyc();

    bus.req1 = 1; bus.addr1 = 8'd65; bus.we1 = 0;
    cyc();
    rq.push_back({1'b1, 8'h01});
    @(negedge clk);
    chk("r1_gnt1", 32'(bus.gnt1), 1);
    chk("r1_gnt0", 32'(bus.gnt0), 0);
    cyc();
    bus.req1 = 0;
    cyc();

    bus.req0 = 1; bus.req1 = 1;
    bus.addr0 = 8'd10; bus.wdata0 = 8'h5A; bus.we0 = 1;
    bus.addr1 = 8'd10; bus.we1 = 0;
    cyc();
    wq.push_back({8'd10, 8'h5A});
    @(negedge clk);
    chk("tie_gnt0", 32'(bus.gnt0), 1);
    chk("tie_gnt1", 32'(bus.gnt1), 0);
    cyc();
    bus.req0 = 0;
    @(negedge clk);
    chk("rel_no_write", 32'(bus.mem_we), 0);
    chk("rel_gnt0", 32'(bus.gnt0), 1);
    cyc();
    rq.push_back({1'b1, 8'h5A});
    @(negedge clk);
    chk("hand_gnt0", 32'(bus.gnt0), 0);
    chk("hand_gnt1", 32'(bus.gnt1), 1);
    chk("hand_addr", 32'(bus.mem_addr), 10);
    cyc();
    bus.req1 = 0;
    cyc();

    bus.req1 = 1; bus.addr1 = 8'd65; bus.we1 = 0;
    cyc();
    bus.clear_start = 1;
    bus.req0 = 1; bus.addr0 = 8'd0; bus.we0 = 0;
    rq.push_back({1'b1, 8'h01});
    @(negedge clk);
    chk("own1_c0", 32'(bus.gnt1), 1);
    for (int k = 1; k < 10; k++) begin
      cyc();
      bus.clear_start = 0;
      rq.push_back({1'b1, 8'h01});
      @(negedge clk);
      chk("own1_hold", 32'(bus.gnt1), 1);
      chk("own1_busy", 32'(bus.clear_busy), 1);
      chk("own1_gnt0", 32'(bus.gnt0), 0);
    end
    cyc();
    bus.req1 = 0;
    push_clear();
    @(negedge clk);
    chk("own1_rel_busy", 32'(bus.clear_busy), 1);
    chk("own1_rel_we", 32'(bus.mem_we), 0);
    wait_done("clr2");
    cyc();
    bus.req0 = 0;
    @(negedge clk);
    chk("gnt0_after_clr", 32'(bus.gnt0), 1);
    cyc();

    bus.clear_start = 1;
    bus.req1 = 1; bus.addr1 = 8'd0; bus.we1 = 0;
    push_clear();
    cyc();
    bus.clear_start = 0;
    bus.req1 = 0;
    @(negedge clk);
    chk("cs_wins_gnt1", 32'(bus.gnt1), 0);
    chk("cs_wins_we", 32'(bus.mem_we), 1);
    for (int i = 0; i < 300; i++) begin
      if (bus.mem_addr == 8'd100) break;
      @(negedge clk);
    end
    chk("abort_addr", 32'(bus.mem_addr), 100);
    #2 reset = 1'b0;
    #1;
    chk("abort_we", 32'(bus.mem_we), 0);
    chk("abort_addr0", 32'(bus.mem_addr), 0);
    chk("abort_data", 32'(bus.mem_data), 0);
    chk("abort_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
    chk("abort_busy", 32'(bus.clear_busy), 1);
    wq.delete();
    push_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_done("clr3");
    @(negedge clk);
    chk("end_wq_empty", 32'(wq.size()), 0);
    chk("end_rq_empty", 32'(rq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
